// File: rtl/inv_sub_bytes_unit.sv
// Iterative AES InvSubBytes stage: substitutes a 128-bit state through
// BYTES_PER_CYCLE inverse s-box lookups per clock, with a start/busy/done handshake.

module inv_s_box_lookup (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = INV_SBOX[i_byte];

endmodule

module inv_sub_bytes_unit #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int unsigned B      = BYTES_PER_CYCLE;
  localparam int unsigned GW     = 8 * B;
  localparam int unsigned GROUPS = 16 / B;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [127:0]    r_work, w_work_nxt;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   w_grp_in, w_grp_out;
  logic            w_last, w_accept;

  assign w_last   = (r_cnt == CW'(GROUPS - 1));
  assign w_accept = start && (r_state != S_SUB);
  assign busy     = (r_state == S_SUB);
  assign done     = (r_state == S_DONE);

  // Group mux: only the group selected by the counter feeds the lookups.
  always_comb begin
    w_grp_in = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (r_cnt == CW'(g)) w_grp_in = r_work[g*GW +: GW];
    end
  end

  for (genvar j = 0; j < B; j++) begin : g_lut
    inv_s_box_lookup u_lut (
      .i_byte (w_grp_in[8*j +: 8]),
      .o_byte (w_grp_out[8*j +: 8])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (r_cnt == CW'(g)) w_work_nxt[g*GW +: GW] = w_grp_out;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SUB;
      S_SUB:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_SUB : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_work    <= '0;
      r_cnt     <= '0;
      state_out <= '0;
    end else if (w_accept) begin
      r_work <= state_in;
      r_cnt  <= '0;
    end else if (r_state == S_SUB) begin
      r_work <= w_work_nxt;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) state_out <= w_work_nxt;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_unit.sv
// Bench for inv_sub_bytes_unit: random and directed jobs checked against an
// inverse s-box derived from GF(2^8) inversion plus the AES affine map.

module tb_inv_sub_bytes_unit;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] state_in = '0;
  logic         busy4, done4, busy1, done1, busy16, done16;
  logic [127:0] out4, out1, out16;

  int errors = 0;
  int checks = 0;
  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  inv_sub_bytes_unit #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .state_in(state_in),
    .busy(busy4), .done(done4), .state_out(out4));

  inv_sub_bytes_unit #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start), .state_in(state_in),
    .busy(busy1), .done(done1), .state_out(out1));

  inv_sub_bytes_unit #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .n_rst(n_rst), .start(start), .state_in(state_in),
    .busy(busy16), .done(done16), .state_out(out16));

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_model();
    logic [7:0] x, inv, s;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tbl[s] = x;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts a job on all instances; returns B=4 done edge (-1 on timeout) and busy cycle count.
  task automatic run_job(input logic [127:0] d, output int done_edge, output int busy_cycles);
    @(negedge clk); start = 1'b1; state_in = d;
    @(negedge clk); start = 1'b0;
    done_edge = -1; busy_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy4) busy_cycles++;
      if (done4) begin done_edge = n; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while ((busy1 || busy4 || busy16 || done1 || done4 || done16) && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL wait_idle: instances still active after %0d cycles, required idle", n); end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 128'h0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d busy=%b done=%b out=%h, required 0/0/0", c, busy4, done4, out4);
      end
    end
  endtask

  task automatic test_zero();
    int de, bc;
    run_job('0, de, bc);
    checks++;
    if (de !== 4) begin errors++; $display("FAIL zero_latency: done edge %0d, required 4", de); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL zero_busy: busy cycles %0d, required 4", bc); end
    checks++;
    if (out4 !== model('0)) begin errors++; $display("FAIL zero_data: out %h, required %h", out4, model('0)); end
    @(negedge clk);
    checks++;
    if (done4 !== 1'b0 || out4 !== model('0)) begin
      errors++; $display("FAIL zero_pulse: done=%b out=%h, required done 0 with held result", done4, out4);
    end
  endtask

  task automatic test_pattern();
    int de, bc;
    logic [127:0] d, e;
    d = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    run_job(d, de, bc);
    checks++;
    if (out4 !== model(d)) begin errors++; $display("FAIL index_pattern: out %h, required %h", out4, model(d)); end
    d = {16{8'h7c}};
    e = {16{8'h01}};
    run_job(d, de, bc);
    checks++;
    if (out4 !== e || out4 !== model(d)) begin errors++; $display("FAIL byte_7c: out %h, required %h", out4, e); end
  endtask

  task automatic test_random();
    int de, bc;
    logic [127:0] d, prev;
    for (int k = 0; k < 8; k++) begin
      d = rand128();
      prev = out4;
      @(negedge clk); start = 1'b1; state_in = d;
      @(negedge clk); start = 1'b0; state_in = rand128();
      checks++;
      if (busy4 !== 1'b1 || out4 !== prev) begin
        errors++; $display("FAIL rand_hold%0d: busy=%b out=%h, required busy 1 out %h", k, busy4, out4, prev);
      end
      de = -1;
      for (int n = 0; n < 40; n++) begin
        if (done4) begin de = n; break; end
        @(negedge clk);
      end
      checks++;
      if (de !== 4 || out4 !== model(d)) begin
        errors++; $display("FAIL rand_job%0d: edge %0d out %h, required edge 4 out %h", k, de, out4, model(d));
      end
    end
    bc = 0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, f;
    int de;
    a = {16{8'h63}};
    f = {16{8'hff}};
    @(negedge clk); start = 1'b1; state_in = a;
    @(negedge clk); start = 1'b0;                      // after edge 0
    @(negedge clk); start = 1'b1; state_in = rand128(); // after edge 1: mid-SUB start
    @(negedge clk); start = 1'b0;                      // after edge 2
    @(negedge clk);                                    // after edge 3
    @(negedge clk);                                    // after edge 4
    checks++;
    if (done4 !== 1'b1 || out4 !== {16{8'h00}}) begin
      errors++; $display("FAIL b2b_jobA: done=%b out=%h, required done 1 out all 00", done4, out4);
    end
    start = 1'b1; state_in = f;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: busy=%b done=%b, required 1/0", busy4, done4);
    end
    de = -1;
    for (int n = 0; n < 40; n++) begin
      if (done4) begin de = n; break; end
      @(negedge clk);
    end
    checks++;
    if (de !== 4 || out4 !== {16{8'h7d}} || out4 !== model(f)) begin
      errors++; $display("FAIL b2b_jobB: edge %0d out %h, required edge 4 out all 7d", de, out4);
    end
  endtask

  task automatic test_reset_mid();
    int de, bc;
    logic [127:0] d;
    @(negedge clk); start = 1'b1; state_in = rand128();
    @(negedge clk); start = 1'b0;   // after edge 0
    @(negedge clk);                 // after edge 1
    @(negedge clk);                 // after edge 2
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 128'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b out=%h, required 0/0/0", busy4, done4, out4);
    end
    @(negedge clk); n_rst = 1'b1;
    d = rand128();
    run_job(d, de, bc);
    checks++;
    if (de !== 4 || out4 !== model(d)) begin
      errors++; $display("FAIL reset_recover: edge %0d out %h, required edge 4 out %h", de, out4, model(d));
    end
  endtask

  task automatic test_sweep();
    logic [127:0] d;
    int e1, e4, e16;
    d = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    wait_all_idle();
    @(negedge clk); start = 1'b1; state_in = d;
    @(negedge clk); start = 1'b0;
    e1 = -1; e4 = -1; e16 = -1;
    for (int n = 0; n < 40; n++) begin
      if (done1  && e1  < 0) e1  = n;
      if (done4  && e4  < 0) e4  = n;
      if (done16 && e16 < 0) e16 = n;
      if (e1 >= 0) break;
      @(negedge clk);
    end
    checks++;
    if (e1 !== 16 || out1 !== model(d)) begin
      errors++; $display("FAIL sweep_b1: edge %0d out %h, required edge 16 out %h", e1, out1, model(d));
    end
    checks++;
    if (e4 !== 4 || out4 !== model(d)) begin
      errors++; $display("FAIL sweep_b4: edge %0d out %h, required edge 4 out %h", e4, out4, model(d));
    end
    checks++;
    if (e16 !== 1 || out16 !== model(d)) begin
      errors++; $display("FAIL sweep_b16: edge %0d out %h, required edge 1 out %h", e16, out16, model(d));
    end
  endtask

  initial begin
    build_model();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    test_reset();
    test_zero();
    test_pattern();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_unit.md
Name: inv_sub_bytes_unit

Overview:
Sequential InvSubBytes stage of the AES decryption datapath. It accepts a 128-bit state from the inverse-ShiftRows stage and substitutes every byte through instances of inv_s_box_lookup, BYTES_PER_CYCLE bytes per clock. It returns the substituted state to the AddRoundKey stage with a start/busy/done handshake. Iterating over the state trades latency for lookup-table area.

Parameters:
BYTES_PER_CYCLE, 4, number of inv_s_box_lookup instances and bytes substituted per SUB cycle; legal values are 1, 2, 4, 8, 16.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  request; sampled on the rising edge and accepted only when busy=0.
state_in  input  128  state to substitute; byte i = bits [8i+7:8i]; captured on the accepting edge only.
busy  output  1  high while substitution is in progress (SUB state).
done  output  1  one-cycle completion pulse.
state_out  output  128  registered result; holds its value between completions.

Behaviour:
- Reset: n_rst low takes effect immediately, with no wait for a clock edge.
  - FSM goes to IDLE.
  - Working register, byte counter and state_out clear to 0.
  - busy=0, done=0.
  - Reset mid-operation aborts the job with no partial result on state_out.
- FSM states: IDLE, SUB, DONE.
  - IDLE: busy=0, done=0. start=1 → capture state_in into the working register, counter=0, go to SUB.
  - SUB: busy=1.
    - Each edge replaces bytes [counter*B .. counter*B+B-1] of the working register with their inverse s-box values (B = BYTES_PER_CYCLE), then counter increments.
    - On the edge that processes the last group (counter = 16/B-1), load the fully substituted value into state_out and go to DONE.
    - start is ignored in SUB; state_in is not re-sampled.
  - DONE: busy=0, done=1 for exactly this cycle.
    - start=1 → capture the new state_in, counter=0, go to SUB. Back-to-back jobs are allowed.
    - Otherwise go to IDLE.
- Latency: counting the start-accepting edge as edge 0, state_out updates and done rises after edge 16/B and is high for one cycle. With the default B=4, done is seen 4 edges after start.
- Throughput: one job per 16/B+1 cycles.
- Byte order: group 0 is the low bytes. Within a group, lookup instance j handles byte counter*B+j.
- Counter width is log2(16/B), minimum 1 bit. The counter never wraps past 16/B-1 while in SUB.
- All outputs are registered. There is no combinational path from start or state_in to any output.
- state_out changes only on completion or reset.

Test Plan:
- Reset then idle: hold start=0 for 10 cycles → busy=0, done=0, state_out=0.
- Zero state: start with state_in=0 → done pulses 4 edges after start; state_out=0x52525252_52525252_52525252_52525252; busy high for exactly 4 cycles.
- Byte-index pattern: state_in=0x0f0e0d0c_0b0a0908_07060504_03020100 → state_out=0xfbd7f381_9ea340bf_38a53630_d56a0952.
  - Also check that byte 0x7c maps to 0x01 and 0xff maps to 0x7d.
- Busy/back-to-back:
  - Job A (state_in all 0x63) gives state_out all 0x00.
  - A start pulse mid-SUB with different data is ignored.
  - start asserted in A's DONE cycle with all 0xff gives a second done pulse 4 edges later and state_out all 0x7d.
- Reset mid-operation: assert n_rst low asynchronously between edges 2 and 3 of a job → busy, done and state_out go to 0 immediately. A new job after release completes normally.
- Parameter sweep: repeat the byte-index pattern at BYTES_PER_CYCLE=1 and 16 → identical state_out, with done after 16 and 1 edges respectively.
